regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Sequential reader that walks the CPU register file through its two read ports (RS/RT address, ReadRS/ReadRT data) and streams every register out over a valid/ready interface.
- Used for debug dump and test-bench state checking; sits beside the register file and shares its read ports when the core is halted.
- Reads two registers per access (even index on RS, odd index on RT), buffers the pair, then emits them one per handshake.

Parameters:
- REG_COUNT, 32, number of registers dumped; must be even and at least 2.
- ADDR_WIDTH, 5, register index width; must satisfy 2^ADDR_WIDTH >= REG_COUNT.
- DATA_WIDTH, 32, register data width.

Ports:
- Clock  input  1  rising-edge clock, same clock as the register file.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  starts a dump when sampled high in IDLE; ignored otherwise.
- Abort  input  1  synchronous; returns the FSM to IDLE at the next edge.
- RS  output  ADDR_WIDTH  read address to register file port 1.
- RT  output  ADDR_WIDTH  read address to register file port 2.
- ReadRS  input  DATA_WIDTH  combinational read data for RS.
- ReadRT  input  DATA_WIDTH  combinational read data for RT.
- DumpValid  output  1  DumpData and DumpIndex are valid.
- DumpReady  input  1  consumer accepts the current word.
- DumpData  output  DATA_WIDTH  register value.
- DumpIndex  output  ADDR_WIDTH  register index of DumpData.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (ResetN low, asynchronous):
  - State goes to IDLE; pair pointer Base = 0; both buffer slots = 0.
  - Outputs: RS = 0, RT = 0, DumpValid = 0, DumpData = 0, DumpIndex = 0, Busy = 0, Done = 0.
- All outputs are registered or decoded from state and registers only. No combinational path from any input to any output.
- States: IDLE, LOAD, SEND0, SEND1, DONE.
- IDLE:
  - RS = RT = 0.
  - Start = 1 -> LOAD with Base = 0.
- LOAD (exactly 1 cycle):
  - RS = Base, RT = Base + 1.
  - At the edge, capture Buf0 <= ReadRS and Buf1 <= ReadRT, then go to SEND0.
- SEND0:
  - DumpValid = 1, DumpData = Buf0, DumpIndex = Base.
  - DumpReady = 1 at an edge -> SEND1; otherwise hold.
- SEND1:
  - DumpValid = 1, DumpData = Buf1, DumpIndex = Base + 1.
  - DumpReady = 1 at an edge:
    - if Base + 2 == REG_COUNT -> DONE;
    - else Base <= Base + 2 and go to LOAD.
- DONE (1 cycle): Done = 1, Busy = 1; then IDLE with Base reset to 0.
- Handshake rules:
  - A word transfers on an edge where DumpValid && DumpReady.
  - While DumpValid = 1 and DumpReady = 0, DumpData and DumpIndex hold stable.
  - DumpValid never deasserts without a transfer, except on Abort or reset.
- Latency:
  - Start sampled at edge k -> LOAD during cycle k+1 -> first DumpValid in cycle k+2.
  - With DumpReady held at 1, a full dump takes 3 × REG_COUNT/2 + 1 cycles from the Start edge to the Done pulse: 49 cycles for 32 registers.
- Abort:
  - Sampled high in any non-IDLE state -> IDLE at the next edge; DumpValid = 0 from that cycle; Base = 0; no Done pulse.
  - Abort has priority over DumpReady in the same cycle; a word presented that cycle counts as not transferred.
  - Abort in IDLE has no effect.
- Start:
  - Start while Busy is ignored.
  - Start and Abort high together in IDLE -> Start wins.
- Consistency:
  - Each pair is a snapshot taken in its LOAD cycle.
  - Register-file writes after that LOAD are not reflected in the buffered pair.
  - Writes to not-yet-loaded registers are reflected.
- Index width: Base + 1 never exceeds REG_COUNT − 1, so there is no wrap. Arithmetic is unsigned, ADDR_WIDTH bits.
- Reset mid-dump: immediate return to the reset values above; a later Start restarts from index 0.

Test Plan:
- Preload R[i] = 32'h1000_0000 + i for all 32 registers; pulse Start with DumpReady = 1 -> 32 transfers, indices 0..31 in order, data matches. RS/RT observed as (0,1),(2,3),…,(30,31). Done pulses once, 49 cycles after the Start edge.
- Same dump with DumpReady toggled 1,0,0,1 repeatedly -> no word lost or duplicated; DumpData/DumpIndex stable across every stall; Busy stays 1 until after Done.
- Assert Abort in SEND1 at Base = 10 with DumpReady = 1 -> DumpValid = 0 next cycle, no Done, Busy = 0. New Start -> first word is index 0.
- Pulse Start again during SEND0 -> ignored; exactly one 32-word dump and one Done pulse.
- Write R[2] = 32'hDEAD_BEEF while the core is in SEND0 for Base = 0 -> dump reports index 2 = 32'hDEAD_BEEF. A write to R[1] in the same window is not reflected (pair already captured).
- Drop ResetN asynchronously during SEND1 -> all outputs at reset values immediately, before the next Clock edge; recovery and full dump succeed after ResetN returns high.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Streams every register of the CPU register file out over a valid/ready port,
// reading an even/odd pair per access through the two register-file read ports.
module regfile_dump_reader #(
   parameter int REG_COUNT  = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  Start,
   input  logic                  Abort,
   output logic [ADDR_WIDTH-1:0] RS,
   output logic [ADDR_WIDTH-1:0] RT,
   input  logic [DATA_WIDTH-1:0] ReadRS,
   input  logic [DATA_WIDTH-1:0] ReadRT,
   output logic                  DumpValid,
   input  logic                  DumpReady,
   output logic [DATA_WIDTH-1:0] DumpData,
   output logic [ADDR_WIDTH-1:0] DumpIndex,
   output logic                  Busy,
   output logic                  Done
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SEND0 = 3'd2,
      ST_SEND1 = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TWO  = ADDR_WIDTH'(2);
   // Compared against Base directly: Base + 2 would wrap at ADDR_WIDTH bits.
   localparam logic [ADDR_WIDTH-1:0] LAST_BASE = ADDR_WIDTH'(REG_COUNT - 2);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   state_t                state_r, state_s;
   logic [ADDR_WIDTH-1:0] base_r,  base_s;
   logic [DATA_WIDTH-1:0] buf0_r,  buf0_s;
   logic [DATA_WIDTH-1:0] buf1_r,  buf1_s;

   // State, pair pointer and pair buffer registers.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_r <= ST_IDLE;
         base_r  <= ADDR_ZERO;
         buf0_r  <= DATA_ZERO;
         buf1_r  <= DATA_ZERO;
      end else begin
         state_r <= state_s;
         base_r  <= base_s;
         buf0_r  <= buf0_s;
         buf1_r  <= buf1_s;
      end
   end

   // Next-state logic; Abort outranks every handshake outside IDLE.
   always_comb begin
      state_s = state_r;
      base_s  = base_r;
      buf0_s  = buf0_r;
      buf1_s  = buf1_r;
      if (Abort && (state_r != ST_IDLE)) begin
         state_s = ST_IDLE;
         base_s  = ADDR_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  state_s = ST_LOAD;
                  base_s  = ADDR_ZERO;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               buf0_s  = ReadRS;
               buf1_s  = ReadRT;
               state_s = ST_SEND0;
            end
            ST_SEND0: begin
               if (DumpReady) begin
                  state_s = ST_SEND1;
               end else begin
                  state_s = ST_SEND0;
               end
            end
            ST_SEND1: begin
               if (!DumpReady) begin
                  state_s = ST_SEND1;
               end else if (base_r == LAST_BASE) begin
                  state_s = ST_DONE;
               end else begin
                  base_s  = base_r + ADDR_TWO;
                  state_s = ST_LOAD;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
               base_s  = ADDR_ZERO;
            end
            default: begin
               state_s = ST_IDLE;
               base_s  = ADDR_ZERO;
            end
         endcase
      end
   end

   // Outputs decoded from state and registers only, so reset clears them at once.
   always_comb begin
      RS        = ADDR_ZERO;
      RT        = ADDR_ZERO;
      DumpValid = 1'b0;
      DumpData  = DATA_ZERO;
      DumpIndex = ADDR_ZERO;
      Done      = 1'b0;
      Busy      = (state_r != ST_IDLE);
      case (state_r)
         ST_LOAD: begin
            RS = base_r;
            RT = base_r + ADDR_ONE;
         end
         ST_SEND0: begin
            DumpValid = 1'b1;
            DumpData  = buf0_r;
            DumpIndex = base_r;
         end
         ST_SEND1: begin
            DumpValid = 1'b1;
            DumpData  = buf1_r;
            DumpIndex = base_r + ADDR_ONE;
         end
         ST_DONE: begin
            Done = 1'b1;
         end
         default: begin
            Done = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed and randomized bench for regfile_dump_reader with an array-based
// register file and a per-register expected-snapshot model.
module tb_regfile_dump_reader;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic          Clock = 1'b0;
   logic          ResetN = 1'b0;
   logic          Start = 1'b0;
   logic          Abort = 1'b0;
   logic [AW-1:0] RS, RT;
   logic [DW-1:0] ReadRS, ReadRT;
   logic          DumpValid;
   logic          DumpReady = 1'b0;
   logic [DW-1:0] DumpData;
   logic [AW-1:0] DumpIndex;
   logic          Busy, Done;

   logic [DW-1:0] rf       [NREG];
   logic [DW-1:0] exp_data [NREG];

   int checks = 0;
   int errors = 0;

   regfile_dump_reader #(.REG_COUNT(NREG), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .Clock(Clock), .ResetN(ResetN), .Start(Start), .Abort(Abort),
      .RS(RS), .RT(RT), .ReadRS(ReadRS), .ReadRT(ReadRT),
      .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpData(DumpData),
      .DumpIndex(DumpIndex), .Busy(Busy), .Done(Done)
   );

   always #5 Clock = ~Clock;

   assign ReadRS = rf[RS];
   assign ReadRT = rf[RT];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rs"}, RS, 0);
      chk({tag, "_rt"}, RT, 0);
      chk({tag, "_valid"}, DumpValid, 0);
      chk({tag, "_data"}, DumpData, 0);
      chk({tag, "_index"}, DumpIndex, 0);
      chk({tag, "_busy"}, Busy, 0);
      chk({tag, "_done"}, Done, 0);
   endtask

   task automatic load_pattern();
      for (int i = 0; i < NREG; i++) rf[i] = 32'h1000_0000 + i;
      for (int i = 0; i < NREG; i++) exp_data[i] = rf[i];
   endtask

   task automatic load_random();
      for (int i = 0; i < NREG; i++) rf[i] = $urandom();
      for (int i = 0; i < NREG; i++) exp_data[i] = rf[i];
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: random ready.
   task automatic run_dump(input int mode, input bit start_again, input bit wr_test);
      int          nidx = 0;
      int          elapsed = 0;
      int          loads = 0;
      int          dones = 0;
      int          phase = 0;
      bit          stall;
      bit          restarted = 1'b0;
      bit          written = 1'b0;
      logic [DW-1:0] hold_data;
      logic [AW-1:0] hold_idx;
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk("busy_after_start", Busy, 1);
      while (dones == 0 && elapsed < 2000) begin
         case (mode)
            0:       DumpReady = 1'b1;
            1:       DumpReady = (phase % 4 == 0) || (phase % 4 == 3);
            default: DumpReady = 1'($urandom_range(0, 1));
         endcase
         phase++;
         Start = 1'b0;
         if (start_again && !restarted && DumpValid && DumpIndex == 5'd4) begin
            Start = 1'b1;
            restarted = 1'b1;
         end
         if (wr_test && !written && DumpValid && DumpIndex == 5'd0) begin
            // Pair 0 is already buffered; pair 1 has not been read yet.
            rf[2] = 32'hDEAD_BEEF;
            rf[1] = 32'h0BAD_F00D;
            exp_data[2] = 32'hDEAD_BEEF;
            written = 1'b1;
         end
         if (RT != 5'd0) begin
            chk("rs_addr", RS, 2 * loads);
            chk("rt_addr", RT, 2 * loads + 1);
            loads++;
         end
         if (DumpValid && DumpReady) begin
            chk("word_index", DumpIndex, nidx);
            chk("word_data", DumpData, exp_data[nidx % NREG]);
            nidx++;
         end
         stall     = DumpValid && !DumpReady;
         hold_data = DumpData;
         hold_idx  = DumpIndex;
         step();
         elapsed++;
         Start = 1'b0;
         if (stall) begin
            chk("stall_valid", DumpValid, 1);
            chk("stall_data", DumpData, hold_data);
            chk("stall_index", DumpIndex, hold_idx);
         end
         if (Done) begin
            dones++;
         end else begin
            chk("busy_during_dump", Busy, 1);
         end
      end
      chk("done_seen", dones, 1);
      chk("word_count", nidx, NREG);
      chk("load_count", loads, NREG / 2);
      chk("busy_in_done", Busy, 1);
      // Done first visible elapsed edges after the Start edge; its cycle ends one edge later.
      if (mode == 0) chk("done_latency", elapsed + 1, 3 * NREG / 2 + 1);
      step();
      chk("done_pulse_width", Done, 0);
      chk("busy_after_done", Busy, 0);
      if (wr_test) chk("write_seen", written, 1);
      if (start_again) begin
         chk("restart_pulsed", restarted, 1);
         repeat (5) begin
            step();
            chk("no_second_dump", Busy, 0);
         end
      end
   endtask

   initial begin
      int n;
      DumpReady = 1'b0;
      load_pattern();

      // Reset state
      step();
      chk_idle_outputs("reset");
      ResetN = 1'b1;
      step();
      chk_idle_outputs("idle");

      // Abort alone in IDLE does nothing; Start beats Abort in IDLE.
      Abort = 1'b1;
      step();
      chk("abort_idle_busy", Busy, 0);
      Start = 1'b1;
      step();
      Start = 1'b0;
      Abort = 1'b0;
      chk("start_wins_busy", Busy, 1);
      chk("start_wins_rt", RT, 1);
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      chk("abort_load_busy", Busy, 0);

      // Full dump, ready held high, then with a stalling consumer
      run_dump(0, 1'b0, 1'b0);
      run_dump(1, 1'b0, 1'b0);

      // Abort in SEND1 at Base = 10
      Start = 1'b1;
      step();
      Start = 1'b0;
      DumpReady = 1'b1;
      n = 0;
      for (int c = 0; c < 200; c++) begin
         if (DumpValid && DumpIndex == 5'd11) break;
         if (DumpValid) n++;
         step();
      end
      chk("abort_reached_idx11", DumpIndex, 11);
      chk("abort_words_before", n, 11);
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      chk("abort_valid", DumpValid, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      step();
      chk("abort_no_done", Done, 0);
      run_dump(0, 1'b0, 1'b0);

      // Start again during SEND0 is ignored
      run_dump(0, 1'b1, 1'b0);

      // Random data, random ready
      load_random();
      run_dump(2, 1'b0, 1'b0);

      // Register writes after / before the pair's snapshot
      load_pattern();
      run_dump(0, 1'b0, 1'b1);

      // Asynchronous reset in SEND1
      load_random();
      Start = 1'b1;
      step();
      Start = 1'b0;
      DumpReady = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (DumpValid && DumpIndex == 5'd7) break;
         step();
      end
      chk("rst_reached_idx7", DumpIndex, 7);
      #2;
      ResetN = 1'b0;
      #1;
      chk_idle_outputs("async_reset");
      #1;
      ResetN = 1'b1;
      step();
      chk_idle_outputs("post_reset");
      load_random();
      run_dump(2, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
